ysyx_23060236_divider: RTL
==========================

Name: ysyx_23060236_divider

Overview:
Iterative radix-2 restoring divider. It is the responder side of the EXU's divide handshake: the EXU raises in_valid, this block raises out_valid when the result is ready.
Implements the RV32M DIV, DIVU, REM and REMU operations with one quotient bit per cycle. The block sits beside the EXU ALU, and the EXU muxes its result onto the writeback value.

Parameters:
WIDTH, 32, operand and result width in bits; counter width is $clog2(WIDTH)+1.

Ports:
clock  in  1  single clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset; block held in reset while 0.
in_valid  in  1  EXU presents a divide request.
in_ready  out  1  block can accept a request; high only in IDLE.
src1  in  WIDTH  dividend.
src2  in  WIDTH  divisor.
funct3  in  2  low bits of the RV funct3 field: 00 DIV, 01 DIVU, 10 REM, 11 REMU. bit0=1 means unsigned; bit1=1 means return the remainder.
flush  in  1  abort the current operation (pipeline redirect).
out_valid  out  1  one-cycle pulse; result is valid in that cycle.
result  out  WIDTH  quotient or remainder; held until the next accept.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - Counter, operand and remainder registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on a rising edge with in_valid & in_ready & ~flush.
  - On accept, latch the op type, sign flags and magnitudes. Signed ops use |src1| and |src2|; unsigned ops use the raw values.
  - On accept: partial remainder=0, counter=0, go to CALC.
- CALC:
  - Each edge, shift {rem,quo} left by one.
  - Trial-subtract the divisor magnitude from the upper WIDTH+1 bits. If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore.
  - counter += 1. After WIDTH iterations (counter==WIDTH-1 at the edge) go to DONE.
- DONE:
  - out_valid=1 for exactly this cycle; result driven from final registers.
  - Next edge returns to IDLE unconditionally. There is no out_ready; the EXU must sample out_valid when it pulses.
- Latency (macro off): out_valid is high in the cycle beginning WIDTH+1 edges after the accepting edge, i.e. 33 cycles for WIDTH=32.
- Sign correction:
  - Quotient is negated if signed op & (src1 sign != src2 sign) & divisor != 0.
  - Remainder is negated if signed op & src1 negative.
- Required results, per RISC-V:
  - Divide by zero: quotient = all ones, remainder = src1, for both signed and unsigned.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
  - These hold with the macro on or off; the macro changes only latency.
- flush:
  - In any state, the next edge forces IDLE and suppresses out_valid.
  - flush in DONE: out_valid is still high in that cycle (the result is already committed); the EXU ignores it.
  - flush with in_valid in IDLE: flush wins and the request is not accepted.
- result register updates only when DONE is entered; otherwise it holds its value.
- in_valid while not in IDLE is ignored; in_ready=0 there.
- Back-to-back operation: the earliest new accept is at the edge that leaves DONE→IDLE plus one cycle, i.e. in_ready is high the cycle after out_valid.

Optional Feature:
DIV_FASTPATH_EN:
- Defined: at accept, divide-by-zero and signed overflow skip CALC and go straight to DONE with the special-case result. out_valid then pulses 1 cycle after the accepting edge.
- Also defined: divisor==1 with an unsigned op takes the same fast path (quotient=src1, remainder=0).
- Undefined: all requests take the full WIDTH+1-cycle path, with identical results.

Test Plan:
- DIVU src1=100 src2=7 -> result=14; out_valid exactly 33 cycles after accept, 1-cycle pulse; in_ready high the next cycle.
- REM src1=0xFFFFFFF9 (-7) src2=2 -> 0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
- DIV src1=0x80000000 src2=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Latency is 1 with DIV_FASTPATH_EN, 33 without.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - REM 0xFFFFFFFB/0 -> 0xFFFFFFFB.
  - Latency as in the previous scenario.
- flush asserted 10 cycles into CALC -> no out_valid ever for that op, in_ready=1 next cycle; a following DIVU 0xFFFFFFFF/0x10 returns 0x0FFFFFFF.
- reset driven low mid-CALC, asynchronously between edges -> out_valid=0 and in_ready=1 immediately; after release, a fresh DIV 20/-3 returns 0xFFFFFFFA (-6).

Source files
------------

// File: rtl/ysyx_23060236_divider.sv
// ysyx_23060236_divider: iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU. One quotient bit per cycle; special cases fall out of
// the plain restoring loop, so results match with or without the fast path.
// Optional macro DIV_FASTPATH_EN: divide-by-zero, signed overflow and
// unsigned divide-by-one bypass the iteration loop and finish in one cycle.
module ysyx_23060236_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [1:0]       funct3,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, WIDTH+1 bits
   logic [WIDTH-1:0] quo_q, quo_d;       // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] div_q, div_d;       // divisor magnitude
   logic [WIDTH-1:0] result_q, result_d;
   logic             is_rem_q, is_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;

   // Operand decode at accept time
   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   // One restoring step
   logic [WIDTH+1:0] partial, trial;
   logic             ge;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] quo_step, quo_fin, rem_fin;
`ifdef DIV_FASTPATH_EN
   logic             fast;
   logic [WIDTH-1:0] fast_quo, fast_rem;
`endif

   // Datapath helpers: operand magnitudes and a single shift/trial-subtract step
   always_comb begin
      signed_op = ~funct3[0];
      a_neg     = signed_op & src1[WIDTH-1];
      b_neg     = signed_op & src2[WIDTH-1];
      a_mag     = a_neg ? -src1 : src1;
      b_mag     = b_neg ? -src2 : src2;
      // Shift {rem,quo} left by one; the upper part gets the quotient MSB.
      // rem < divisor < 2^WIDTH, so a negative trial always sets the top bit.
      partial   = {rem_q, quo_q[WIDTH-1]};
      trial     = partial - {2'b00, div_q};
      ge        = ~trial[WIDTH+1];
      rem_step  = ge ? trial[WIDTH:0] : partial[WIDTH:0];
      quo_step  = {quo_q[WIDTH-2:0], ge};
      quo_fin   = neg_quo_q ? -quo_step : quo_step;
      rem_fin   = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
`ifdef DIV_FASTPATH_EN
      fast      = (src2 == '0)
                | (signed_op & (src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (src2 == '1))
                | (~signed_op & (src2 == WIDTH'(1)));
      fast_quo  = (src2 == '0) ? '1 : src1;
      fast_rem  = (src2 == '0) ? src1 : '0;
`endif
   end

   // Next-state and register update logic; flush overrides everything
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      result_d  = result_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               is_rem_d  = funct3[1];
               neg_quo_d = signed_op & (a_neg ^ b_neg) & (src2 != '0);
               neg_rem_d = a_neg;
               quo_d     = a_mag;
               div_d     = b_mag;
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = CALC;
`ifdef DIV_FASTPATH_EN
               if (fast) begin
                  state_d  = DONE;
                  result_d = funct3[1] ? fast_rem : fast_quo;
               end
`endif
            end
         end
         CALC: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = DONE;
               result_d = is_rem_q ? rem_fin : quo_fin;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         result_q  <= result_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
endmodule
